// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the decoder/mux slice and its internal default slave.
// Also holds the helper that recognises an active (NONSEQ/SEQ) transfer.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Internal default slave: two-cycle ERROR response for unmapped NONSEQ/SEQ accesses,
// zero-wait OKAY for everything else.
//
// state   | meaning
// DS_IDLE | no error in progress, HREADYOUT=1 HRESP=OKAY
// DS_ERR1 | first error cycle, HREADYOUT=0 HRESP=ERROR
// DS_ERR2 | second error cycle, HREADYOUT=1 HRESP=ERROR
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sel,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    ds_state_t state;
    ds_state_t state_next;
    logic      accept;

    assign accept = HREADY && sel && trans_active(HTRANS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (accept) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP      = HRESP_ERROR;
                state_next = accept ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahb_decode_mux.sv
// Parametrised AHB-Lite address decoder and slave response multiplexer with an
// internal default slave and a sticky decode-error log for debug.
module ahb_decode_mux
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SLAVE_COUNT  = 4,
    parameter int REGION_BITS  = 4,
    parameter logic [SLAVE_COUNT*REGION_BITS-1:0] REGION_MAP = {4'h3, 4'h2, 4'h1, 4'h0},
    parameter int ERRCNT_WIDTH = 8
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic [ADDR_WIDTH-1:0]             HADDR,
    input  logic [1:0]                        HTRANS,
    output logic [SLAVE_COUNT-1:0]            HSEL,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [SLAVE_COUNT-1:0]            HREADYOUT_S,
    input  logic [SLAVE_COUNT-1:0]            HRESP_S,
    output logic [DATA_WIDTH-1:0]             HRDATA,
    output logic                              HREADY,
    output logic                              HRESP,
    output logic                              DEC_ERR,
    output logic [ADDR_WIDTH-1:0]             DEC_ERR_ADDR,
    output logic [ERRCNT_WIDTH-1:0]           DEC_ERR_CNT,
    input  logic                              DEC_ERR_CLR
);

    // Bit SLAVE_COUNT of the owner vector is the internal default slave.
    localparam logic [SLAVE_COUNT:0] DP_DEFAULT = {1'b1, {SLAVE_COUNT{1'b0}}};

    logic [REGION_BITS-1:0] tag;
    logic [SLAVE_COUNT-1:0] hsel_dec;
    logic                   hit_none;
    logic [SLAVE_COUNT:0]   dp_sel;
    logic                   ds_hreadyout;
    logic                   ds_hresp;
    logic                   err_accept;

    assign tag = HADDR[ADDR_WIDTH-1 -: REGION_BITS];

    // Lowest index wins on duplicate tags so the select stays one-hot.
    always_comb begin
        logic found;
        found    = 1'b0;
        hsel_dec = '0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (!found && (tag == REGION_MAP[i*REGION_BITS +: REGION_BITS])) begin
                hsel_dec[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign HSEL     = hsel_dec;
    assign hit_none = ~|hsel_dec;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel <= DP_DEFAULT;
        end else if (HREADY) begin
            dp_sel <= {hit_none, hsel_dec};
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        if (dp_sel[SLAVE_COUNT]) begin
            HREADY = ds_hreadyout;
            HRESP  = ds_hresp;
        end
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            if (dp_sel[i]) begin
                HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .sel       (hit_none),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp)
    );

    assign err_accept = HREADY && hit_none && trans_active(HTRANS);

    // Clear has priority so software never loses a clear to a racing error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            DEC_ERR      <= 1'b0;
            DEC_ERR_ADDR <= '0;
            DEC_ERR_CNT  <= '0;
        end else if (DEC_ERR_CLR) begin
            DEC_ERR      <= 1'b0;
            DEC_ERR_ADDR <= '0;
            DEC_ERR_CNT  <= '0;
        end else if (err_accept) begin
            if (DEC_ERR_CNT != {ERRCNT_WIDTH{1'b1}}) begin
                DEC_ERR_CNT <= DEC_ERR_CNT + 1'b1;
            end
            if (!DEC_ERR) begin
                DEC_ERR      <= 1'b1;
                DEC_ERR_ADDR <= HADDR;
            end
        end
    end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed bench for ahb_decode_mux: default 4-slave map plus a 2-slave duplicate-tag map,
// data-phase expectations queued at issue time and checked when HREADY completes the phase.
module tb_ahb_decode_mux;
    import ahb_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        resp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  haddr = '0;
    logic [1:0]   htrans = HTRANS_IDLE;
    logic [3:0]   hsel;
    logic [127:0] hrdata_s = {32'h3333_3333, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h1111_1111};
    logic [3:0]   hreadyout_s = 4'hF;
    logic [3:0]   hresp_s = 4'h0;
    logic [31:0]  hrdata;
    logic         hready;
    logic         hresp;
    logic         dec_err;
    logic [31:0]  dec_err_addr;
    logic [7:0]   dec_err_cnt;
    logic         clr = 1'b0;

    logic [31:0]  haddr2 = '0;
    logic [1:0]   htrans2 = HTRANS_IDLE;
    logic [1:0]   hsel2;
    logic [63:0]  hrdata_s2 = {32'h2222_2222, 32'h7777_7777};
    logic [1:0]   hreadyout_s2 = 2'b11;
    logic [1:0]   hresp_s2 = 2'b00;
    logic [31:0]  hrdata2;
    logic         hready2;
    logic         hresp2;
    logic         dec_err2;
    logic [31:0]  dec_err_addr2;
    logic [7:0]   dec_err_cnt2;
    logic         clr2 = 1'b0;

    always #5 clk = ~clk;

    ahb_decode_mux dut (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
        .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .DEC_ERR(dec_err),
        .DEC_ERR_ADDR(dec_err_addr), .DEC_ERR_CNT(dec_err_cnt), .DEC_ERR_CLR(clr)
    );

    ahb_decode_mux #(
        .SLAVE_COUNT(2),
        .REGION_MAP ({4'h5, 4'h5})
    ) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr2), .HTRANS(htrans2), .HSEL(hsel2),
        .HRDATA_S(hrdata_s2), .HREADYOUT_S(hreadyout_s2), .HRESP_S(hresp_s2),
        .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2), .DEC_ERR(dec_err2),
        .DEC_ERR_ADDR(dec_err_addr2), .DEC_ERR_CNT(dec_err_cnt2), .DEC_ERR_CLR(clr2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] t, input string tag,
                         input logic [31:0] d, input logic r);
        haddr  = a;
        htrans = t;
        sb.push_back('{tag: tag, data: d, resp: r});
    endtask

    // Wait (bounded) for the data phase to complete, then compare against the queue head.
    task automatic drain();
        int   budget;
        exp_t e;
        budget = 20;
        while (!hready && budget > 0) begin
            tick();
            budget--;
        end
        chk("hready_timeout", 64'(hready), 64'h1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'h1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_hrdata"}, 64'(hrdata), 64'(e.data));
            chk({e.tag, "_hresp"}, 64'(hresp), 64'(e.resp));
        end
    endtask

    initial begin
        int n_acc;
        int exp_cnt;

        haddr = 32'h2000_0010;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hready", 64'(hready), 64'h1);
        chk("rst_hresp", 64'(hresp), 64'h0);
        chk("rst_hrdata", 64'(hrdata), 64'h0);
        chk("rst_dec_err", 64'(dec_err), 64'h0);
        chk("rst_dec_err_addr", 64'(dec_err_addr), 64'h0);
        chk("rst_dec_err_cnt", 64'(dec_err_cnt), 64'h0);
        chk("rst_hsel", 64'(hsel), 64'h4);
        #20 rst_n = 1'b1;
        tick();

        // Basic read from slave 2
        issue(32'h2000_0010, HTRANS_NONSEQ, "s2_read", 32'hA5A5_A5A5, HRESP_OKAY);
        #1 chk("s2_hsel", 64'(hsel), 64'h4);
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        drain();
        tick();

        // Slave 1 with three wait states while the next address is presented
        hreadyout_s[1] = 1'b0;
        issue(32'h1000_0000, HTRANS_NONSEQ, "s1_wait", 32'h5A5A_5A5A, HRESP_OKAY);
        tick();
        issue(32'h3000_0000, HTRANS_NONSEQ, "s3_after_wait", 32'h3333_3333, HRESP_OKAY);
        #1;
        chk("wait1_hready", 64'(hready), 64'h0);
        chk("wait1_hsel", 64'(hsel), 64'h8);
        tick();
        chk("wait2_hready", 64'(hready), 64'h0);
        tick();
        chk("wait3_hready", 64'(hready), 64'h0);
        tick();
        hreadyout_s[1] = 1'b1;
        #1;
        drain();
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        drain();
        tick();

        // First unmapped NONSEQ: two-cycle ERROR and sticky capture
        issue(32'h8000_0004, HTRANS_NONSEQ, "unmapped1", 32'h0, HRESP_ERROR);
        #1 chk("unmapped_hsel", 64'(hsel), 64'h0);
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        chk("err1_hready", 64'(hready), 64'h0);
        chk("err1_hresp", 64'(hresp), 64'h1);
        chk("cap_dec_err", 64'(dec_err), 64'h1);
        chk("cap_dec_err_addr", 64'(dec_err_addr), 64'h8000_0004);
        chk("cap_dec_err_cnt", 64'(dec_err_cnt), 64'h1);
        tick();
        drain();
        tick();

        // Unmapped IDLE: zero-wait OKAY, no count
        issue(32'h8000_0000, HTRANS_IDLE, "unmapped_idle", 32'h0, HRESP_OKAY);
        tick();
        chk("idle_zero_wait", 64'(hready), 64'h1);
        drain();
        chk("idle_cnt", 64'(dec_err_cnt), 64'h1);
        issue(32'h9000_0000, HTRANS_SEQ, "unmapped_seq", 32'h0, HRESP_ERROR);
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        chk("seq_err1_hready", 64'(hready), 64'h0);
        tick();
        drain();
        chk("seq_cnt", 64'(dec_err_cnt), 64'h2);
        chk("seq_addr_kept", 64'(dec_err_addr), 64'h8000_0004);
        tick();

        // Back-to-back unmapped: ERR1, ERR2, ERR1, ERR2
        issue(32'hA000_0000, HTRANS_NONSEQ, "b2b_a", 32'h0, HRESP_ERROR);
        tick();
        issue(32'hB000_0000, HTRANS_SEQ, "b2b_b", 32'h0, HRESP_ERROR);
        chk("b2b_err1a_hready", 64'(hready), 64'h0);
        tick();
        drain();
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        chk("b2b_err1b_hready", 64'(hready), 64'h0);
        chk("b2b_err1b_hresp", 64'(hresp), 64'h1);
        tick();
        drain();
        chk("b2b_cnt", 64'(dec_err_cnt), 64'h4);
        tick();

        // Slave ERROR response passes through the mux
        hresp_s[0] = 1'b1;
        issue(32'h0000_0100, HTRANS_NONSEQ, "s0_error", 32'h1111_1111, HRESP_ERROR);
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        drain();
        hresp_s[0] = 1'b0;

        // Software clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_dec_err", 64'(dec_err), 64'h0);
        chk("clr_dec_err_addr", 64'(dec_err_addr), 64'h0);
        chk("clr_dec_err_cnt", 64'(dec_err_cnt), 64'h0);

        // Two-slave map with duplicate tags, saturation and clear-vs-capture
        haddr2 = 32'h5000_0000;
        #1 chk("dup_tag_hsel", 64'(hsel2), 64'h1);
        haddr2  = 32'h6000_0000;
        htrans2 = HTRANS_NONSEQ;
        #1 chk("dut2_unmapped_hsel", 64'(hsel2), 64'h0);
        n_acc = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            n_acc++;
            exp_cnt = (n_acc > 255) ? 255 : n_acc;
            if (k == 0) begin
                chk("dut2_err1_hready", 64'(hready2), 64'h0);
                chk("dut2_err1_hresp", 64'(hresp2), 64'h1);
            end
            if (k == 150 || k == 299) begin
                chk("dut2_cnt", 64'(dec_err_cnt2), 64'(exp_cnt));
            end
            tick();
            if (k == 0) begin
                chk("dut2_err2_hready", 64'(hready2), 64'h1);
                chk("dut2_err2_hresp", 64'(hresp2), 64'h1);
            end
        end
        chk("dut2_sat", 64'(dec_err_cnt2), 64'hFF);
        chk("dut2_dec_err", 64'(dec_err2), 64'h1);
        chk("dut2_dec_err_addr", 64'(dec_err_addr2), 64'h6000_0000);
        clr2 = 1'b1;
        tick();
        clr2    = 1'b0;
        htrans2 = HTRANS_IDLE;
        chk("clr_race_cnt", 64'(dec_err_cnt2), 64'h0);
        chk("clr_race_dec_err", 64'(dec_err2), 64'h0);
        chk("clr_race_addr", 64'(dec_err_addr2), 64'h0);
        tick();
        tick();

        // Asynchronous reset during ERR1
        haddr  = 32'hC000_0000;
        htrans = HTRANS_NONSEQ;
        tick();
        haddr  = 32'h0;
        htrans = HTRANS_IDLE;
        chk("pre_rst_hready", 64'(hready), 64'h0);
        chk("pre_rst_dec_err", 64'(dec_err), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_hready", 64'(hready), 64'h1);
        chk("async_rst_hresp", 64'(hresp), 64'h0);
        chk("async_rst_hrdata", 64'(hrdata), 64'h0);
        chk("async_rst_dec_err", 64'(dec_err), 64'h0);
        chk("async_rst_cnt", 64'(dec_err_cnt), 64'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_hready", 64'(hready), 64'h1);
        chk("post_rst_hresp", 64'(hresp), 64'h0);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_decode_mux.md
# ahb_decode_mux

Parametrised AHB-Lite address decoder and slave response multiplexer, the successor to the fixed four-slave decoder. It sits between the single AHB master and N slaves. It generates HSEL from a parameter-programmed region map and tracks the data-phase owner in a register. It routes the owner's HRDATA/HREADYOUT/HRESP back to the master and provides an internal default slave that returns a two-cycle ERROR response for unmapped accesses. A sticky decode-error capture and a saturating counter support debug.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HRDATA width
- SLAVE_COUNT, 4, number of slaves, 1..16
- REGION_BITS, 4, number of HADDR MSBs used for decode
- REGION_MAP, {4'h3,4'h2,4'h1,4'h0}, flattened SLAVE_COUNT×REGION_BITS region tags; slave i owns tag REGION_MAP[i*REGION_BITS +: REGION_BITS]
- ERRCNT_WIDTH, 8, decode-error counter width

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  ADDR_WIDTH  master address
- HTRANS  in  2  master transfer type
- HSEL  out  SLAVE_COUNT  one-hot slave select (combinational, address phase)
- HRDATA_S  in  SLAVE_COUNT×DATA_WIDTH  flattened slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- HREADYOUT_S  in  SLAVE_COUNT  slave ready outputs
- HRESP_S  in  SLAVE_COUNT  slave responses (1 = ERROR)
- HRDATA  out  DATA_WIDTH  muxed read data to master
- HREADY  out  1  muxed ready, to master and all slaves
- HRESP  out  1  muxed response to master
- DEC_ERR  out  1  sticky flag, first decode error since reset or clear
- DEC_ERR_ADDR  out  ADDR_WIDTH  HADDR of the first unmapped NONSEQ/SEQ access
- DEC_ERR_CNT  out  ERRCNT_WIDTH  saturating count of unmapped NONSEQ/SEQ accesses
- DEC_ERR_CLR  in  1  synchronous clear of DEC_ERR, DEC_ERR_ADDR and DEC_ERR_CNT

## Operation
- Decode: tag = HADDR[ADDR_WIDTH-1 -: REGION_BITS]. HSEL[i] = (tag == map tag i). On duplicate tags the lowest index wins, so HSEL stays one-hot. No match gives HSEL = 0 and selects the default slave (hit_none).
- Data-phase owner register dp_sel (SLAVE_COUNT+1 one-hot, bit SLAVE_COUNT = default slave). It loads the address-phase selection when HREADY = 1, otherwise it holds.
- Output mux: if the owner is slave i, HRDATA/HREADY/HRESP = HRDATA_S[i]/HREADYOUT_S[i]/HRESP_S[i]. If the owner is the default slave, HRDATA = 0 and HREADY/HRESP come from the default-slave FSM.
- Default slave FSM states:
  - DS_IDLE: outputs HREADY=1, HRESP=0.
  - DS_ERR1: outputs HREADY=0, HRESP=1.
  - DS_ERR2: outputs HREADY=1, HRESP=1.
- Default slave FSM transitions:
  - DS_IDLE→DS_ERR1 when HREADY=1 and hit_none and HTRANS[1]=1 (NONSEQ/SEQ).
  - DS_ERR1→DS_ERR2 unconditionally.
  - DS_ERR2→DS_ERR1 if a new unmapped NONSEQ/SEQ is accepted this cycle, else DS_IDLE.
- Unmapped IDLE/BUSY transfers get a zero-wait OKAY, meaning the FSM stays in DS_IDLE.
- Error log, on each accepted unmapped NONSEQ/SEQ:
  - DEC_ERR_CNT increments and saturates at all-ones.
  - If DEC_ERR = 0, DEC_ERR_ADDR captures HADDR and DEC_ERR is set.
- DEC_ERR_CLR wins over a simultaneous capture. The counter is cleared to 0, and a same-cycle event is not counted.

## Timing
- Reset values:
  - dp_sel = default slave, FSM = DS_IDLE.
  - Outputs HREADY=1, HRESP=0, HRDATA=0, DEC_ERR=0, DEC_ERR_ADDR=0, DEC_ERR_CNT=0.
  - HSEL follows HADDR combinationally, even during reset.
- HSEL has zero latency. The response mux switches one cycle after an accepted address phase (AHB pipeline).
- Slave wait states stretch the data phase. dp_sel holds, and the next address is not re-latched until HREADY = 1.
- An unmapped access costs exactly 2 data-phase cycles. Back-to-back unmapped accesses give the repeating pattern ERR1, ERR2, ERR1, ERR2.
- HRESETn asserted mid-transfer immediately forces the reset values (asynchronous). The first post-reset cycle is a clean DS_IDLE data phase.

## Structure
- The package ahb_pkg holds the HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), the HRESP encodings and the default-slave state encodings.
- The sub-module ahb_default_slave contains the FSM, with ports HCLK, HRESETn, sel, HTRANS, HREADY, HREADYOUT, HRESP.
- The top level holds the decode, dp_sel, the mux and the error log.

## Test plan
- Reset, then HADDR=0x2000_0010 with NONSEQ: HSEL=4'b0100. The next cycle returns HRDATA_S[2]=0xA5A5_A5A5 on HRDATA with HRESP=0.
- Slave 1 inserts 3 wait states: HREADY stays low for 3 cycles. dp_sel stays on slave 1 while HADDR changes to 0x3000_0000.
- NONSEQ to 0x8000_0004: HSEL=0. The data phase shows HREADY=0/HRESP=1, then HREADY=1/HRESP=1. DEC_ERR=1, DEC_ERR_ADDR=0x8000_0004, DEC_ERR_CNT=1.
- IDLE to 0x8000_0000: zero-wait OKAY and no counter change. A second unmapped SEQ to 0x9000_0000 gives CNT=2 with DEC_ERR_ADDR unchanged.
- SLAVE_COUNT=2, REGION_MAP={4'h5,4'h5}: HADDR=0x5000_0000 gives HSEL=2'b01. 300 unmapped accesses saturate the counter at 255. DEC_ERR_CLR coinciding with an error leaves CNT=0.
- Assert HRESETn during DS_ERR1: the outputs return to their reset values in the same cycle.
